l1_request_sequencer: RTL

Upstream stage of the L2 cache model: it accepts parsed trace records (command + address) from the trace reader, buffers them in a small FIFO, and issues them one at a time to the L2 cache's L1-side operation interface. Each operation uses a valid/ready handshake and waits for the cache's completion pulse. The block keeps hit/miss/read/write statistics and handles the control commands: clear (8) and print (9). It sits between the trace file reader and the L2 cache in the simulator top level.

---
 rtl/l1_request_sequencer_if.sv | 43 ++++
 rtl/l1_request_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_request_sequencer_if.sv
// ---------------------------------------------------------------------------
// l1_request_sequencer_if
//   Groups the trace-record input handshake and the L1-side cache operation
//   handshake used by l1_request_sequencer.
//
//   Trace input   : in_valid, in_ready, in_command, in_address
//   Cache op side : l1_op_valid, l1_op_ready, l1_command, l1_address,
//                   l1_done, l1_hit
//
//   modport master : the sequencer view (accepts trace records and issues
//                    operations to the cache)
//   modport slave  : the environment view (trace reader + L2 cache)
// ---------------------------------------------------------------------------
interface l1_request_sequencer_if #(
  parameter int COMMAND_SIZE = 8,
  parameter int ADDRESS_SIZE = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [COMMAND_SIZE-1:0] in_command;
  logic [ADDRESS_SIZE-1:0] in_address;

  logic                    l1_op_valid;
  logic                    l1_op_ready;
  logic [COMMAND_SIZE-1:0] l1_command;
  logic [ADDRESS_SIZE-1:0] l1_address;
  logic                    l1_done;
  logic                    l1_hit;

  modport master (
    input  in_valid, in_command, in_address,
    output in_ready,
    output l1_op_valid, l1_command, l1_address,
    input  l1_op_ready, l1_done, l1_hit
  );

  modport slave (
    output in_valid, in_command, in_address,
    input  in_ready,
    input  l1_op_valid, l1_command, l1_address,
    output l1_op_ready, l1_done, l1_hit
  );
endinterface

// File: rtl/l1_request_sequencer.sv
// ---------------------------------------------------------------------------
// l1_request_sequencer
//   Buffers parsed trace records in a small FIFO and issues them one at a
//   time to the L2 cache's L1-side operation interface, waiting for the
//   cache's completion pulse after each accepted operation. Handles the
//   control commands clear (8) and print (9) and keeps statistics.
//
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     bus (master)    : trace input handshake + cache operation handshake
//     print_stats     : one-cycle pulse when a print command is executed
//     busy            : FSM not idle or FIFO not empty (combinational)
//     timeout_err     : sticky, set when the cache never completes an op
//     read_count, write_count, hit_count, miss_count, drop_count :
//                       saturating 32-bit statistics
//
//   Build option: define L2_SEQ_STATS_EN to build the statistics counters.
//   Without it all five count outputs are tied to zero; clear still takes
//   its cycle and print still pulses.
// ---------------------------------------------------------------------------
module l1_request_sequencer #(
  parameter int COMMAND_SIZE   = 8,
  parameter int ADDRESS_SIZE   = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  l1_request_sequencer_if.master bus,
  output logic        print_stats,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] read_count,
  output logic [31:0] write_count,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [COMMAND_SIZE-1:0] CMD_READ     = COMMAND_SIZE'(0);
  localparam logic [COMMAND_SIZE-1:0] CMD_WRITE    = COMMAND_SIZE'(1);
  localparam logic [COMMAND_SIZE-1:0] CMD_IFETCH   = COMMAND_SIZE'(2);
  localparam logic [COMMAND_SIZE-1:0] CMD_LAST_OP  = COMMAND_SIZE'(6);
  localparam logic [COMMAND_SIZE-1:0] CMD_CLEAR    = COMMAND_SIZE'(8);
  localparam logic [COMMAND_SIZE-1:0] CMD_PRINT    = COMMAND_SIZE'(9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_PRINT
  } state_t;

  // FIFO storage (data only, never reset) and control
  logic [COMMAND_SIZE-1:0] r_mem_cmd  [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0] r_mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  // FSM and registered outputs
  state_t                  r_state;
  logic                    r_op_valid;
  logic [COMMAND_SIZE-1:0] r_cmd;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic                    r_print;
  logic                    r_tmo_err;
  logic [TMO_W-1:0]        r_tmo;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [COMMAND_SIZE-1:0] w_head_cmd;
  logic [ADDRESS_SIZE-1:0] w_head_addr;
  logic                    w_is_op;
  logic                    w_is_clear;
  logic                    w_is_print;
  logic                    w_drop;
  logic                    w_done;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.in_valid && !w_full;
  // The FSM consumes the head whenever it is idle, including records that
  // turn out to be illegal and are simply discarded.
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head_cmd  = r_mem_cmd[r_rd_ptr];
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_is_op     = (w_head_cmd <= CMD_LAST_OP);
  assign w_is_clear  = (w_head_cmd == CMD_CLEAR);
  assign w_is_print  = (w_head_cmd == CMD_PRINT);
  assign w_drop      = w_pop && !w_is_op && !w_is_clear && !w_is_print;
  // Completions are only meaningful while an operation is outstanding.
  assign w_done      = (r_state == S_WAIT) && bus.l1_done;

  assign bus.in_ready    = !w_full;
  assign bus.l1_op_valid = r_op_valid;
  assign bus.l1_command  = r_cmd;
  assign bus.l1_address  = r_addr;
  assign print_stats     = r_print;
  assign timeout_err     = r_tmo_err;
  assign busy            = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr]  <= bus.in_command;
      r_mem_addr[r_wr_ptr] <= bus.in_address;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_valid <= 1'b0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_print    <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_print <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_is_op) begin
              r_state    <= S_ISSUE;
              r_op_valid <= 1'b1;
              r_cmd      <= w_head_cmd;
              r_addr     <= w_head_addr;
            end else if (w_is_clear) begin
              r_state <= S_CLEAR;
            end else if (w_is_print) begin
              r_state <= S_PRINT;
              r_print <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (bus.l1_op_ready) begin
            r_state    <= S_WAIT;
            r_op_valid <= 1'b0;
            r_tmo      <= '0;
          end
        end
        S_WAIT: begin
          if (bus.l1_done) begin
            r_state <= S_IDLE;
          end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th cycle spent waiting: give up.
            r_state   <= S_IDLE;
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_CLEAR: r_state <= S_IDLE;
        S_PRINT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_SEQ_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_read_cnt;
  logic [31:0] r_write_cnt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else if (r_state == S_CLEAR) begin
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
      if (w_done) begin
        // Snoop commands (3..6) only touch hit/miss.
        if (r_cmd == CMD_READ || r_cmd == CMD_IFETCH) r_read_cnt <= sat_inc(r_read_cnt);
        if (r_cmd == CMD_WRITE) r_write_cnt <= sat_inc(r_write_cnt);
        if (bus.l1_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
        else            r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  assign read_count  = r_read_cnt;
  assign write_count = r_write_cnt;
  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign drop_count  = r_drop_cnt;
`else
  logic w_unused;
  assign w_unused    = &{1'b0, w_drop, w_done, bus.l1_hit};
  assign read_count  = '0;
  assign write_count = '0;
  assign hit_count   = '0;
  assign miss_count  = '0;
  assign drop_count  = '0;
`endif

endmodule
